// File: rtl/flop_sched_pkg.sv
// Shared types and the round-robin pick function for the flop write scheduler.
package flop_sched_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns {found, idx}: first requester at or after ptr, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input idx_t ptr);
    logic found;
    idx_t idx;
    idx_t cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + idx_t'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/flop_wr_sched_if.sv
// Requester-side bundle of the flop write scheduler: requests, data and status.
interface flop_wr_sched_if
  import flop_sched_pkg::*;
#(
  parameter int size = 1
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*size-1:0] d;
  logic                 hold;
  logic [size-1:0]      q;
  logic [NREQ-1:0]      gnt;
  logic                 en_o;
  idx_t                 owner;
  logic                 locked;
  logic [7:0]           conflicts;

  modport master (
    output req, lock, d, hold,
    input  q, gnt, en_o, owner, locked, conflicts
  );

  modport slave (
    input  req, lock, d, hold,
    output q, gnt, en_o, owner, locked, conflicts
  );
endinterface

// File: rtl/flop_sched_rr.sv
// Combinational round-robin picker: first active request starting at ptr.
module flop_sched_rr
  import flop_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            found,
  output idx_t            idx
);

  assign {found, idx} = rr_pick(req, ptr);

endmodule

// File: rtl/flop_wr_sched.sv
// Round-robin scheduler sharing one enabled register among four requesters,
// with per-requester lock and a saturating contention counter; negedge clocked.
module flop_wr_sched
  import flop_sched_pkg::*;
#(
  parameter int size = 1
) (
  input  logic           clk,
  input  logic           reset,
  flop_wr_sched_if.slave bus
);

  state_t          state;
  idx_t            ptr;
  idx_t            owner;
  logic [size-1:0] q;
  logic [NREQ-1:0] gnt;
  logic [7:0]      conflicts;

  logic            found;
  idx_t            widx;
  logic            multi;
  logic [size-1:0] d_win;
  logic [size-1:0] d_own;

  flop_sched_rr u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (widx)
  );

  assign multi = ($countones(bus.req) >= 2);
  assign d_win = bus.d[int'(widx)*size +: size];
  assign d_own = bus.d[int'(owner)*size +: size];

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      q         <= '0;
      gnt       <= '0;
      conflicts <= '0;
    end else if (bus.hold) begin
      gnt <= '0;
    end else begin
      if (multi && conflicts != 8'hFF) begin
        conflicts <= conflicts + 8'd1;
      end
      case (state)
        ARB: begin
          if (found) begin
            q   <= d_win;
            gnt <= NREQ'(1) << widx;
            ptr <= widx + idx_t'(1);
            if (bus.lock[widx]) begin
              state <= LOCKED;
              owner <= widx;
            end
          end else begin
            gnt <= '0;
          end
        end
        LOCKED: begin
          // Owner keeps the register; everyone else waits and ptr is frozen.
          if (bus.req[owner]) begin
            q   <= d_own;
            gnt <= NREQ'(1) << owner;
            if (!bus.lock[owner]) begin
              state <= ARB;
            end
          end else begin
            gnt   <= '0;
            state <= ARB;
          end
        end
        default: begin
          state <= ARB;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.q         = q;
  assign bus.gnt       = gnt;
  assign bus.en_o      = |gnt;
  assign bus.owner     = owner;
  assign bus.locked    = (state == LOCKED);
  assign bus.conflicts = conflicts;

endmodule

// File: tb/tb_flop_wr_sched.sv
// Scoreboard bench for flop_wr_sched (size=4): directed scenarios plus random traffic.
module tb_flop_wr_sched;

  localparam int SZ = 4;

  logic clk;
  logic reset;

  flop_wr_sched_if #(.size(SZ)) bus ();

  flop_wr_sched #(.size(SZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SZ-1:0] q;
    logic [3:0]    gnt;
    logic          locked;
    logic [1:0]    owner;
    logic [7:0]    conf;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_ptr;
  int m_owner;
  int m_locked;
  int m_q;
  int m_conf;
  int m_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_locked = 0; m_q = 0; m_conf = 0; m_gnt = 0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic [3:0] lock,
                            input logic [4*SZ-1:0] d, input logic hold);
    int n, w;
    exp_t e;
    if (hold) begin
      m_gnt = 0;
    end else begin
      n = $countones(req);
      if (n >= 2 && m_conf < 255) m_conf++;
      if (m_locked == 0) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (w >= 0) begin
          m_q   = int'(d[w*SZ +: SZ]);
          m_gnt = 1 << w;
          m_ptr = (w + 1) % 4;
          if (lock[w]) begin
            m_locked = 1;
            m_owner  = w;
          end
        end else begin
          m_gnt = 0;
        end
      end else if (req[m_owner]) begin
        m_q   = int'(d[m_owner*SZ +: SZ]);
        m_gnt = 1 << m_owner;
        if (!lock[m_owner]) m_locked = 0;
      end else begin
        m_gnt    = 0;
        m_locked = 0;
      end
    end
    e.q      = SZ'(m_q);
    e.gnt    = 4'(m_gnt);
    e.locked = (m_locked != 0);
    e.owner  = 2'(m_owner);
    e.conf   = 8'(m_conf);
    exp_q.push_back(e);
  endtask

  // Drive one edge's inputs, queue the expectation, and advance past the edge.
  task automatic step(input logic [3:0] req, input logic [3:0] lock,
                      input logic [4*SZ-1:0] d, input logic hold);
    bus.req  = req;
    bus.lock = lock;
    bus.d    = d;
    bus.hold = hold;
    model_edge(req, lock, d, hold);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q",         32'(bus.q),         32'(e.q));
      check("gnt",       32'(bus.gnt),       32'(e.gnt));
      check("en_o",      32'(bus.en_o),      32'(|e.gnt));
      check("locked",    32'(bus.locked),    32'(e.locked));
      if (e.locked) check("owner", 32'(bus.owner), 32'(e.owner));
      check("conflicts", 32'(bus.conflicts), 32'(e.conf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [5];
    logic [3:0] qseq [5];
    logic [3:0] q_before;
    int guard;
    gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    qseq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

    reset = 1'b1;
    bus.req = '0; bus.lock = '0; bus.d = '0; bus.hold = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_q0", 32'(bus.q), 32'd0);
    check("rst_locked0", 32'(bus.locked), 32'd0);
    reset = 1'b0;

    // Rotation
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, 16'h4321, 1'b0);
      check("rot_gnt", 32'(bus.gnt), 32'(gseq[i]));
      check("rot_q",   32'(bus.q),   32'(qseq[i]));
    end
    check("rot_conf", 32'(bus.conflicts), 32'd5);

    // Move ptr to 2, then lock requester 2 for three edges
    step(4'b0010, 4'b0000, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 4'b0100, 16'h0B0A + 16'(i << 8), 1'b0);
      check("lock_gnt",    32'(bus.gnt),    32'b0100);
      check("lock_locked", 32'(bus.locked), 32'd1);
      check("lock_owner",  32'(bus.owner),  32'd2);
    end
    step(4'b0101, 4'b0000, 16'h0E0A, 1'b0);
    check("unlock_gnt",    32'(bus.gnt),    32'b0100);
    check("unlock_locked", 32'(bus.locked), 32'd0);
    step(4'b0101, 4'b0000, 16'h0E0A, 1'b0);
    check("after_unlock_gnt", 32'(bus.gnt), 32'b0001);

    // Lock owner 1, then release by dropping its request
    step(4'b0010, 4'b0010, 16'h0070, 1'b0);
    check("own1_locked", 32'(bus.locked), 32'd1);
    check("own1_owner",  32'(bus.owner),  32'd1);
    q_before = bus.q;
    step(4'b0001, 4'b0000, 16'h0009, 1'b0);
    check("drop_gnt",    32'(bus.gnt),    32'd0);
    check("drop_locked", 32'(bus.locked), 32'd0);
    check("drop_q",      32'(bus.q),      32'(q_before));
    step(4'b0001, 4'b0000, 16'h0009, 1'b0);
    check("drop_next_gnt", 32'(bus.gnt), 32'b0001);

    // Hold plus saturation
    guard = 0;
    while (m_conf < 254 && guard < 400) begin
      step(4'b0011, 4'b0000, 16'h0021, 1'b0);
      guard++;
    end
    check("preload_conf", 32'(bus.conflicts), 32'hFE);
    step(4'b0011, 4'b0000, 16'h0065, 1'b0);
    check("sat1", 32'(bus.conflicts), 32'hFF);
    step(4'b0011, 4'b0000, 16'h0087, 1'b1);
    check("sat2", 32'(bus.conflicts), 32'hFF);
    check("hold_gnt", 32'(bus.gnt), 32'd0);
    step(4'b0011, 4'b0000, 16'h00A9, 1'b0);
    check("sat3", 32'(bus.conflicts), 32'hFF);

    // Idle
    q_before = bus.q;
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 4'b0000, 16'($urandom), 1'b0);
      check("idle_q",   32'(bus.q),   32'(q_before));
      check("idle_gnt", 32'(bus.gnt), 32'd0);
    end

    // Async reset mid-run with q=A, during a lock
    step(4'b0001, 4'b0001, 16'h000A, 1'b0);
    check("pre_rst_q", 32'(bus.q), 32'hA);
    #2;
    reset = 1'b1;
    #1;
    check("arst_q",      32'(bus.q),         32'd0);
    check("arst_gnt",    32'(bus.gnt),       32'd0);
    check("arst_conf",   32'(bus.conflicts), 32'd0);
    check("arst_locked", 32'(bus.locked),    32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 4'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    bus.req = '0; bus.hold = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flop_wr_sched.md
Name: flop_wr_sched

Overview:
- Round-robin write scheduler that shares one enabled register (q <= d when en) among four requesters.
- Picks one winner per falling clock edge and steers its data into the shared register.
- Supports a lock so a winner can own the register for consecutive writes.
- Counts contention cycles.
- Sits in front of negedge-clocked storage in the flopcode family, so all state updates on negedge clk.

Parameters:
- size, 1, width of each data word and of q.

Ports:
- clk  input  1  clock; all state changes on negedge clk.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester write request; bit i is requester i.
- lock  input  4  per-requester lock; meaningful only together with req[i].
- d  input  4*size  packed data; requester i occupies d[i*size +: size].
- hold  input  1  freeze; blocks all updates.
- q  output  size  shared register contents.
- gnt  output  4  one-hot grant for the write performed at the last negedge; 0 if there was no write.
- en_o  output  1  equals |gnt; high when q was written at the last negedge.
- owner  output  2  index of the current lock owner; valid only while locked=1.
- locked  output  1  high in state LOCKED.
- conflicts  output  8  saturating count of edges with two or more requests.

Behaviour:
- Reset (posedge reset, asynchronous, at any time including mid-lock) sets: q=0, gnt=0, en_o=0, ptr=0, state=ARB, owner=0, locked=0, conflicts=0.
- Deasserting reset takes effect at the next negedge.
- State is ptr[1:0] (next requester with priority) plus an FSM with states ARB and LOCKED.
- Arbitration in ARB:
  - winner w = first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
  - If a winner exists: q<=d[w]; gnt<=1<<w; ptr<=w+1 mod 4.
  - If lock[w]=1: state<=LOCKED and owner<=w.
  - If no request: q holds, gnt<=0, ptr holds.
- LOCKED:
  - If req[owner]=1: q<=d[owner] and gnt<=1<<owner. All other requests are ignored and ptr holds.
  - If lock[owner]=0 at that edge, state<=ARB after the write; this write is the last locked one.
  - If req[owner]=0: no write, gnt<=0, state<=ARB. The release edge performs no arbitration; arbitration resumes at the next edge.
- hold=1 overrides everything: q, ptr, state, owner and conflicts all hold, and gnt<=0.
- conflicts increments by 1 when popcount(req)>=2 and hold=0, in either state. It saturates at 8'hFF and never wraps.
- Latency:
  - A request seen at negedge N updates q at N; gnt/en_o are valid from N until N+1.
  - Requesters in ARB must hold req until they see gnt. Dropping req earlier is legal and simply loses the slot, since there is no pending capture.
- Fairness: in ARB with no locks, a continuously held request is granted within 4 edges.
- lock[i] without req[i] is ignored.
- Grant is always one-hot or zero. A write never occurs without a matching gnt bit.
- Width: with size=1, d is 4 bits. No arithmetic on data; q is a pure mux-and-register.

Decomposition:
- Shared package flop_sched_pkg holds:
  - state enum {ARB, LOCKED}.
  - constant NREQ=4 and the 2-bit index type.
  - function rr_pick(req, ptr) returning {found, idx}.
- One sub-module: flop_sched_rr, the combinational round-robin picker (req, ptr -> found, idx). The top keeps the FSM, q, counter and grant registers.

Test Plan:
- Reset: assert reset mid-run with size=4 and q=4'hA -> q=0, gnt=0, conflicts=0, locked=0 immediately, before any clock edge.
- Rotation: size=4, req=4'b1111, d={4'h4,4'h3,4'h2,4'h1}, lock=0, 5 negedges -> gnt sequence 0001,0010,0100,1000,0001; q sequence 1,2,3,4,1; conflicts=5.
- Lock: req=4'b0101, lock=4'b0100, ptr=2 -> requester 2 is granted 3 edges running (locked=1, owner=2). Then lock[2]=0 -> one more write by requester 2, then next edge grants 0001.
- Lock release by dropping req: owner 1 locked, req=4'b0001 -> edge gives gnt=0, locked=0, q unchanged. Following edge gives gnt=0001.
- Hold plus saturation: preload conflicts to 8'hFE. req=4'b0011 for 3 edges with hold=1 on the 2nd -> conflicts 8'hFF, 8'hFF, 8'hFF; gnt=0 on the hold edge; ptr is unchanged across the hold.
- Idle: req=0 for 10 edges -> q holds its value, gnt=0, en_o=0, ptr unchanged.
